// File: rtl/io_ctrl_sequencer_pkg.sv
// rtl/io_ctrl_sequencer_pkg.sv - opcode, ALU-op and state encodings for the control sequencer
package cpu_ctrl_pkg;

  localparam int OP_W = 5;

  // IR[31:27] opcodes handled by the sequencer
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // ALU function codes driven on alu_op; zero means pass/none
  localparam logic [4:0] ALU_NONE = 5'b00000;
  localparam logic [4:0] ALU_ADD  = 5'b00011;
  localparam logic [4:0] ALU_AND  = 5'b00101;
  localparam logic [4:0] ALU_OR   = 5'b00110;

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    T0     = 4'd1,
    T1     = 4'd2,
    T2     = 4'd3,
    T3     = 4'd4,
    T4     = 4'd5,
    T5     = 4'd6,
    S_HALT = 4'd7,
    S_STEP = 4'd8
  } state_t;

  // Instruction class latched when leaving T2; drives the T3..T5 strobes
  typedef enum logic [2:0] {
    K_NOP  = 3'd0,
    K_ADDI = 3'd1,
    K_ANDI = 3'd2,
    K_ORI  = 3'd3,
    K_IN   = 3'd4,
    K_OUT  = 3'd5,
    K_HALT = 3'd6
  } op_kind_t;

  // Unknown opcodes fall back to NOP
  function automatic op_kind_t decode_op(input logic [4:0] op);
    case (op)
      OP_ADDI: return K_ADDI;
      OP_ANDI: return K_ANDI;
      OP_ORI:  return K_ORI;
      OP_IN:   return K_IN;
      OP_OUT:  return K_OUT;
      OP_HALT: return K_HALT;
      default: return K_NOP;
    endcase
  endfunction

endpackage

// File: rtl/io_ctrl_sequencer_if.sv
// rtl/io_ctrl_sequencer_if.sv - control strobes between sequencer (master) and data_path (slave)
interface io_ctrl_sequencer_if #(
  parameter int OP_W = 5
);
  logic [OP_W-1:0] ir_op;
  logic            Run;
  logic            PCout, Zlowout, MDRout, Cout, InPortout;
  logic            MARin, PCin, MDRin, IRin, Yin, ZHighin, Zlowin, OutPortin;
  logic            IncPC, Read, Gra, Grb, Rin, Rout, BAOut;
  logic [OP_W-1:0] alu_op;

  modport master (
    input  ir_op,
    output Run,
    output PCout, Zlowout, MDRout, Cout, InPortout,
    output MARin, PCin, MDRin, IRin, Yin, ZHighin, Zlowin, OutPortin,
    output IncPC, Read, Gra, Grb, Rin, Rout, BAOut,
    output alu_op
  );

  modport slave (
    output ir_op,
    input  Run,
    input  PCout, Zlowout, MDRout, Cout, InPortout,
    input  MARin, PCin, MDRin, IRin, Yin, ZHighin, Zlowin, OutPortin,
    input  IncPC, Read, Gra, Grb, Rin, Rout, BAOut,
    input  alu_op
  );
endinterface

// File: rtl/io_ctrl_sequencer_wait_ctr.sv
// rtl/io_ctrl_sequencer_wait_ctr.sv - loadable down-counter stretching T1 for memory latency
module ctrl_wait_ctr #(
  parameter int W = 3
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // reload on T1 entry, then count down once per T1 cycle, saturating at zero
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/io_ctrl_sequencer.sv
// rtl/io_ctrl_sequencer.sv - Moore control FSM for data_path; CTRL_SINGLE_STEP_EN adds step input and S_STEP
module io_ctrl_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 1,
  parameter int OP_W     = 5
) (
  input  logic Clock,
  input  logic clear,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic step,
`endif
  io_ctrl_sequencer_if.master bus
);

  localparam int CW = 3;
  localparam logic [CW-1:0] W_MEM_WAIT = CW'(MEM_WAIT);

  // where the FSM goes once an instruction has finished
`ifdef CTRL_SINGLE_STEP_EN
  localparam state_t ST_AFTER = S_STEP;
`else
  localparam state_t ST_AFTER = T0;
`endif

  state_t   r_state;
  state_t   w_next;
  op_kind_t r_kind;
  op_kind_t w_kind_next;
  logic     w_wait_zero;
  logic     w_step_go;

  ctrl_wait_ctr #(
    .W (CW)
  ) u_wait_ctr (
    .i_clk      (Clock),
    .i_rst      (clear),
    .i_load     (r_state == T0),
    .i_load_val (W_MEM_WAIT),
    .i_dec      (r_state == T1),
    .o_zero     (w_wait_zero)
  );

`ifdef CTRL_SINGLE_STEP_EN
  logic r_step_d;

  // previous step level, so a held step releases only one instruction
  always_ff @(posedge Clock) begin
    if (clear) begin
      r_step_d <= 1'b0;
    end else begin
      r_step_d <= step;
    end
  end

  assign w_step_go = step && !r_step_d;
`else
  assign w_step_go = 1'b1;
`endif

  // state and latched instruction class; clear aborts any instruction in flight
  always_ff @(posedge Clock) begin
    if (clear) begin
      r_state <= S_RST;
      r_kind  <= K_NOP;
    end else begin
      r_state <= w_next;
      r_kind  <= w_kind_next;
    end
  end

  // next-state decode; ir_op is only looked at on the edge that leaves T2
  always_comb begin
    w_next      = r_state;
    w_kind_next = r_kind;
    case (r_state)
      S_RST: w_next = T0;
      T0:    w_next = T1;
      T1:    if (w_wait_zero) w_next = T2;
      T2: begin
        w_kind_next = decode_op(bus.ir_op[4:0]);
        case (w_kind_next)
          K_NOP:   w_next = ST_AFTER;
          K_HALT:  w_next = S_HALT;
          default: w_next = T3;
        endcase
      end
      T3:     w_next = ((r_kind == K_IN) || (r_kind == K_OUT)) ? ST_AFTER : T4;
      T4:     w_next = T5;
      T5:     w_next = ST_AFTER;
      S_HALT: w_next = S_HALT;
      S_STEP: if (w_step_go) w_next = T0;
      default: w_next = S_RST;
    endcase
  end

  // Moore strobes decoded from registered state, class and wait count only
  always_comb begin
    bus.Run       = 1'b0;
    bus.PCout     = 1'b0;
    bus.Zlowout   = 1'b0;
    bus.MDRout    = 1'b0;
    bus.Cout      = 1'b0;
    bus.InPortout = 1'b0;
    bus.MARin     = 1'b0;
    bus.PCin      = 1'b0;
    bus.MDRin     = 1'b0;
    bus.IRin      = 1'b0;
    bus.Yin       = 1'b0;
    bus.ZHighin   = 1'b0;
    bus.Zlowin    = 1'b0;
    bus.OutPortin = 1'b0;
    bus.IncPC     = 1'b0;
    bus.Read      = 1'b0;
    bus.Gra       = 1'b0;
    bus.Grb       = 1'b0;
    bus.Rin       = 1'b0;
    bus.Rout      = 1'b0;
    bus.BAOut     = 1'b0;
    bus.alu_op    = OP_W'(ALU_NONE);
    case (r_state)
      T0: begin
        bus.Run     = 1'b1;
        bus.PCout   = 1'b1;
        bus.MARin   = 1'b1;
        bus.IncPC   = 1'b1;
        bus.ZHighin = 1'b1;
        bus.Zlowin  = 1'b1;
      end
      T1: begin
        bus.Run     = 1'b1;
        bus.Zlowout = 1'b1;
        bus.Read    = 1'b1;
        bus.MDRin   = 1'b1;
        bus.PCin    = w_wait_zero;
      end
      T2: begin
        bus.Run    = 1'b1;
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      T3: begin
        bus.Run = 1'b1;
        case (r_kind)
          K_IN: begin
            bus.InPortout = 1'b1;
            bus.Gra       = 1'b1;
            bus.Rin       = 1'b1;
          end
          K_OUT: begin
            bus.Gra       = 1'b1;
            bus.Rout      = 1'b1;
            bus.OutPortin = 1'b1;
          end
          default: begin
            bus.Grb   = 1'b1;
            bus.BAOut = 1'b1;
            bus.Rout  = 1'b1;
            bus.Yin   = 1'b1;
          end
        endcase
      end
      T4: begin
        bus.Run     = 1'b1;
        bus.Cout    = 1'b1;
        bus.ZHighin = 1'b1;
        bus.Zlowin  = 1'b1;
        case (r_kind)
          K_ANDI:  bus.alu_op = OP_W'(ALU_AND);
          K_ORI:   bus.alu_op = OP_W'(ALU_OR);
          default: bus.alu_op = OP_W'(ALU_ADD);
        endcase
      end
      T5: begin
        bus.Run     = 1'b1;
        bus.Zlowout = 1'b1;
        bus.Gra     = 1'b1;
        bus.Rin     = 1'b1;
      end
      S_STEP: bus.Run = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_io_ctrl_sequencer.sv
// tb/tb_io_ctrl_sequencer.sv - cycle-stream checks of io_ctrl_sequencer at MEM_WAIT 0 and 2
module tb_io_ctrl_sequencer;
  import cpu_ctrl_pkg::*;

  // expected-vector bit positions
  localparam logic [25:0] M_RUN   = 26'd1 << 25;
  localparam logic [25:0] M_PCO   = 26'd1 << 24;
  localparam logic [25:0] M_ZLO   = 26'd1 << 23;
  localparam logic [25:0] M_MDRO  = 26'd1 << 22;
  localparam logic [25:0] M_CO    = 26'd1 << 21;
  localparam logic [25:0] M_INPO  = 26'd1 << 20;
  localparam logic [25:0] M_MARI  = 26'd1 << 19;
  localparam logic [25:0] M_PCI   = 26'd1 << 18;
  localparam logic [25:0] M_MDRI  = 26'd1 << 17;
  localparam logic [25:0] M_IRI   = 26'd1 << 16;
  localparam logic [25:0] M_YI    = 26'd1 << 15;
  localparam logic [25:0] M_ZHI   = 26'd1 << 14;
  localparam logic [25:0] M_ZLI   = 26'd1 << 13;
  localparam logic [25:0] M_OUTPI = 26'd1 << 12;
  localparam logic [25:0] M_INC   = 26'd1 << 11;
  localparam logic [25:0] M_RD    = 26'd1 << 10;
  localparam logic [25:0] M_GRA   = 26'd1 << 9;
  localparam logic [25:0] M_GRB   = 26'd1 << 8;
  localparam logic [25:0] M_RIN   = 26'd1 << 7;
  localparam logic [25:0] M_ROUT  = 26'd1 << 6;
  localparam logic [25:0] M_BAO   = 26'd1 << 5;

  typedef struct {
    logic        clr;
    logic        stp;
    logic [4:0]  op;
    logic [25:0] exp;
  } rec_t;

  rec_t q[$];
  int   total = 0;
  int   bad   = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr0 = 1'b1;
  logic clr2 = 1'b1;
`ifdef CTRL_SINGLE_STEP_EN
  logic stp0 = 1'b0;
  logic stp2 = 1'b0;
`endif

  io_ctrl_sequencer_if #(.OP_W(5)) bus0 ();
  io_ctrl_sequencer_if #(.OP_W(5)) bus2 ();

  io_ctrl_sequencer #(.MEM_WAIT(0), .OP_W(5)) u_dut0 (
    .Clock (clk),
    .clear (clr0),
`ifdef CTRL_SINGLE_STEP_EN
    .step  (stp0),
`endif
    .bus   (bus0.master)
  );

  io_ctrl_sequencer #(.MEM_WAIT(2), .OP_W(5)) u_dut2 (
    .Clock (clk),
    .clear (clr2),
`ifdef CTRL_SINGLE_STEP_EN
    .step  (stp2),
`endif
    .bus   (bus2.master)
  );

  logic [25:0] w_v0, w_v2;
  assign w_v0 = {bus0.Run, bus0.PCout, bus0.Zlowout, bus0.MDRout, bus0.Cout, bus0.InPortout,
                 bus0.MARin, bus0.PCin, bus0.MDRin, bus0.IRin, bus0.Yin, bus0.ZHighin, bus0.Zlowin,
                 bus0.OutPortin, bus0.IncPC, bus0.Read, bus0.Gra, bus0.Grb, bus0.Rin, bus0.Rout,
                 bus0.BAOut, bus0.alu_op};
  assign w_v2 = {bus2.Run, bus2.PCout, bus2.Zlowout, bus2.MDRout, bus2.Cout, bus2.InPortout,
                 bus2.MARin, bus2.PCin, bus2.MDRin, bus2.IRin, bus2.Yin, bus2.ZHighin, bus2.Zlowin,
                 bus2.OutPortin, bus2.IncPC, bus2.Read, bus2.Gra, bus2.Grb, bus2.Rin, bus2.Rout,
                 bus2.BAOut, bus2.alu_op};

  function automatic void push(input logic clr, input logic stp, input logic [4:0] op,
                               input logic [25:0] exp);
    rec_t r;
    r.clr = clr;
    r.stp = stp;
    r.op  = op;
    r.exp = exp;
    q.push_back(r);
  endfunction

  // Expected cycles of one instruction, written straight from the T-step table
  function automatic void gen_instr(input logic [4:0] op, input int mw);
    logic [25:0] alu;
    bit arith;
    arith = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
    alu = (op == OP_ANDI) ? 26'(ALU_AND) : (op == OP_ORI) ? 26'(ALU_OR) : 26'(5'b00011);
    push(1'b0, 1'b0, op, M_RUN | M_PCO | M_MARI | M_INC | M_ZHI | M_ZLI);
    for (int i = 0; i <= mw; i++)
      push(1'b0, 1'b0, op, M_RUN | M_ZLO | M_RD | M_MDRI | ((i == mw) ? M_PCI : 26'd0));
    push(1'b0, 1'b0, op, M_RUN | M_MDRO | M_IRI);
    if (op == OP_HALT) return;
    if (arith) begin
      push(1'b0, 1'b0, op, M_RUN | M_GRB | M_BAO | M_ROUT | M_YI);
      push(1'b0, 1'b0, op, M_RUN | M_CO | M_ZHI | M_ZLI | alu);
      push(1'b0, 1'b0, op, M_RUN | M_ZLO | M_GRA | M_RIN);
    end else if (op == OP_OUT) begin
      push(1'b0, 1'b0, op, M_RUN | M_GRA | M_ROUT | M_OUTPI);
    end else if (op == OP_IN) begin
      push(1'b0, 1'b0, op, M_RUN | M_INPO | M_GRA | M_RIN);
    end
`ifdef CTRL_SINGLE_STEP_EN
    begin
      int k;
      k = $urandom_range(0, 3);
      for (int i = 0; i < k; i++) push(1'b0, 1'b0, op, M_RUN);
      push(1'b0, 1'b1, op, M_RUN);
    end
`endif
  endfunction

  function automatic void build(input int mw);
    int base;
    logic [4:0] pool [6];
    logic [4:0] op;
    pool[0] = OP_ADDI; pool[1] = OP_ANDI; pool[2] = OP_ORI;
    pool[3] = OP_IN;   pool[4] = OP_OUT;  pool[5] = OP_NOP;
    q.delete();
    // reset: clear held, then one S_RST cycle before T0
    push(1'b1, 1'b0, 5'd0, 26'd0);
    push(1'b1, 1'b0, 5'd0, 26'd0);
    push(1'b0, 1'b0, 5'd0, 26'd0);
    gen_instr(OP_ADDI, mw);
    gen_instr(OP_OUT, mw);
    gen_instr(OP_IN, mw);
    gen_instr(OP_NOP, mw);
    gen_instr(5'b11111, mw);
    // clear raised during T4 of an ADDI
    base = q.size();
    gen_instr(OP_ADDI, mw);
    while (q.size() > base + mw + 5) void'(q.pop_back());
    q[q.size()-1].clr = 1'b1;
    push(1'b0, 1'b0, 5'd0, 26'd0);
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        op = 5'($urandom);
        if (op == OP_HALT) op = OP_NOP;
      end else begin
        op = pool[$urandom_range(0, 5)];
      end
      gen_instr(op, mw);
    end
    // HALT parks with everything low until clear
    gen_instr(OP_HALT, mw);
    for (int i = 0; i < 22; i++) push(1'b0, 1'b0, 5'($urandom), 26'd0);
    q[q.size()-1].clr = 1'b1;
    push(1'b0, 1'b0, 5'd0, 26'd0);
    gen_instr(OP_ADDI, mw);
  endfunction

  task automatic run(input int which);
    logic [25:0] v;
    for (int i = 0; i < q.size(); i++) begin
      @(posedge clk);
      #1;
      v = (which == 0) ? w_v0 : w_v2;
      total++;
      if (v !== q[i].exp) begin
        bad++;
        $display("FAIL outputs dut_mw%0d rec %0d: got %h want %h", which, i, v, q[i].exp);
      end
      total++;
      if (!$onehot0({v[24:20], v[6]})) begin
        bad++;
        $display("FAIL bus_onehot dut_mw%0d rec %0d: got %b want onehot0", which, i,
                 {v[24:20], v[6]});
      end
      if (which == 0) begin
        clr0 = q[i].clr;
        bus0.ir_op = q[i].op;
`ifdef CTRL_SINGLE_STEP_EN
        stp0 = q[i].stp;
`endif
      end else begin
        clr2 = q[i].clr;
        bus2.ir_op = q[i].op;
`ifdef CTRL_SINGLE_STEP_EN
        stp2 = q[i].stp;
`endif
      end
    end
  endtask

  initial begin
    bus0.ir_op = 5'd0;
    bus2.ir_op = 5'd0;
    clr0 = 1'b1;
    clr2 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    build(0);
    run(0);
    #1 clr0 = 1'b1;
    build(2);
    run(2);
    #1 clr2 = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
